// File: rtl/sudoku_pkg.sv
// sudoku_pkg: state encoding, error codes and default geometry shared by the Sudoku loader.
// Rev 1.0
`default_nettype none

package sudoku_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_DUP   = 2'b10;

  localparam int DEFAULT_BOX = 3;

endpackage

`default_nettype wire

// File: rtl/sudoku_rc_tracker.sv
// sudoku_rc_tracker: walks cells in raster order, producing row/col/box indices without division.
// Rev 1.0
`default_nettype none

module sudoku_rc_tracker
  import sudoku_pkg::*;
#(
  parameter int BOX = DEFAULT_BOX,
  parameter int AW  = $clog2(BOX*BOX*BOX*BOX),
  localparam int NW = $clog2(BOX*BOX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [NW-1:0] row_o,
  output logic [NW-1:0] col_o,
  output logic [NW-1:0] box_o,
  output logic [AW-1:0] idx_o,
  output logic          last_o
);

  localparam int N     = BOX*BOX;
  localparam int CELLS = N*N;
  localparam logic [NW-1:0] C_NMAX = NW'(N-1);
  localparam logic [NW-1:0] C_BMAX = NW'(BOX-1);
  localparam logic [NW-1:0] C_STEP = NW'(BOX);
  localparam logic [AW-1:0] C_LAST = AW'(CELLS-1);

  // cib/rib: position inside the current box; bc_q/br_q: box column and box-row base
  logic [NW-1:0] row_q, col_q, cib_q, rib_q, bc_q, br_q;
  logic [AW-1:0] idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0; col_q <= '0; cib_q <= '0; rib_q <= '0; bc_q <= '0; br_q <= '0;
      idx_q <= '0;
    end else if (clear_i) begin
      row_q <= '0; col_q <= '0; cib_q <= '0; rib_q <= '0; bc_q <= '0; br_q <= '0;
      idx_q <= '0;
    end else if (advance_i && (idx_q != C_LAST)) begin
      idx_q <= idx_q + 1'b1;
      if (col_q == C_NMAX) begin
        col_q <= '0;
        cib_q <= '0;
        bc_q  <= '0;
        row_q <= row_q + 1'b1;
        if (rib_q == C_BMAX) begin
          rib_q <= '0;
          br_q  <= br_q + C_STEP;
        end else begin
          rib_q <= rib_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
        if (cib_q == C_BMAX) begin
          cib_q <= '0;
          bc_q  <= bc_q + 1'b1;
        end else begin
          cib_q <= cib_q + 1'b1;
        end
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign box_o  = br_q + bc_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/sudoku_load_check.sv
// sudoku_load_check: streams a grid from ROM, checks range/row/col/box rules, then copies it to RAM.
// Rev 1.0
`default_nettype none

module sudoku_load_check
  import sudoku_pkg::*;
#(
  parameter int BOX       = DEFAULT_BOX,
  parameter int AW        = $clog2(BOX*BOX*BOX*BOX),
  parameter int WR_ON_ERR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ROM_rd,
  output logic [AW-1:0] ROM_A,
  input  logic [7:0]    ROM_Q,
  output logic          RAM_ceb,
  output logic          RAM_web,
  output logic [AW-1:0] RAM_A,
  output logic [7:0]    RAM_D,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_idx
);

  localparam int N     = BOX*BOX;
  localparam int CELLS = N*N;
  localparam int NW    = $clog2(N);
  localparam logic [AW-1:0] C_LAST = AW'(CELLS-1);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_cnt_q, wr_cnt_q;
  logic          rd_end_q, cap_q;
  logic [1:0]    err_code_q, err_code_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic [7:0]    grid_q [CELLS];
  logic [N-1:0]  rowmask_q [N];
  logic [N-1:0]  colmask_q [N];
  logic [N-1:0]  boxmask_q [N];

  logic [NW-1:0] w_row, w_col, w_box;
  logic [AW-1:0] w_idx;
  logic          w_last, w_start_acc, w_range, w_digit, w_dup;
  logic [N-1:0]  w_onehot;

  assign w_start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  sudoku_rc_tracker #(.BOX(BOX), .AW(AW)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_start_acc),
    .advance_i(cap_q),
    .row_o    (w_row),
    .col_o    (w_col),
    .box_o    (w_box),
    .idx_o    (w_idx),
    .last_o   (w_last)
  );

  // Digit v maps to mask bit v-1; zero is an empty cell and never flags
  always_comb begin
    w_range  = (ROM_Q > 8'(N));
    w_digit  = (ROM_Q != 8'd0) && !w_range;
    w_onehot = w_digit ? (N'(1) << (ROM_Q - 8'd1)) : '0;
    w_dup    = |(w_onehot & (rowmask_q[w_row] | colmask_q[w_col] | boxmask_q[w_box]));
  end

  always_comb begin
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    if (w_start_acc) begin
      err_code_d = ERR_NONE;
      err_idx_d  = '0;
    end else if (cap_q && (err_code_q == ERR_NONE)) begin
      if (w_range) begin
        err_code_d = ERR_RANGE;
        err_idx_d  = w_idx;
      end else if (w_dup) begin
        err_code_d = ERR_DUP;
        err_idx_d  = w_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ROM_rd  = 1'b0;
    ROM_A   = '0;
    RAM_ceb = 1'b0;
    RAM_web = 1'b1;
    RAM_A   = '0;
    RAM_D   = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ROM_rd = !rd_end_q;
        ROM_A  = rd_end_q ? '0 : rd_cnt_q;
        // The last capture's own error must count toward the write decision
        if (cap_q && w_last)
          state_d = ((err_code_d == ERR_NONE) || (WR_ON_ERR != 0)) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        RAM_ceb = 1'b1;
        RAM_web = 1'b0;
        RAM_A   = wr_cnt_q;
        RAM_D   = grid_q[wr_cnt_q];
        if (wr_cnt_q == C_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_end_q   <= 1'b0;
      cap_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
      for (int i = 0; i < N; i++) begin
        rowmask_q[i] <= '0;
        colmask_q[i] <= '0;
        boxmask_q[i] <= '0;
      end
    end else begin
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      cap_q      <= ROM_rd;
      if (w_start_acc) begin
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
        rd_end_q <= 1'b0;
        for (int i = 0; i < N; i++) begin
          rowmask_q[i] <= '0;
          colmask_q[i] <= '0;
          boxmask_q[i] <= '0;
        end
      end else begin
        if (ROM_rd) begin
          if (rd_cnt_q == C_LAST) rd_end_q <= 1'b1;
          else                    rd_cnt_q <= rd_cnt_q + 1'b1;
        end
        if (RAM_ceb && (wr_cnt_q != C_LAST)) wr_cnt_q <= wr_cnt_q + 1'b1;
        if (cap_q && w_digit && !w_dup) begin
          rowmask_q[w_row] <= rowmask_q[w_row] | w_onehot;
          colmask_q[w_col] <= colmask_q[w_col] | w_onehot;
          boxmask_q[w_box] <= boxmask_q[w_box] | w_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      for (int i = 0; i < CELLS; i++) grid_q[i] <= '0;
    end else if (cap_q) begin
      grid_q[w_idx] <= ROM_Q;
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

endmodule

`default_nettype wire
